// File: rtl/ext_bus_responder.sv
// ext_bus_responder: target for the MCU external multiplexed address/data bus.
// Demultiplexes a 32-bit address from two AE phases, latches the write byte on
// AE release, and serves byte reads/writes from internal memory after a
// programmable number of wait states, signalling completion on EXT_READY.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   AE          address enable from the MCU
//   EXT_AD_OUT  multiplexed address/data driven by the MCU (16 bits)
//   EXT_READ    read strobe (level)
//   EXT_WRITE   write strobe (level)
//   EXT_AD_IN   read data to the MCU, 8'h00 whenever EXT_READY is low
//   EXT_READY   access complete (registered)
//
// Optional feature: define EXT_RESP_AUTOINC_EN to post-increment the low
// address bits after every completed access (wrapping within the device).
module ext_bus_responder #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AE,
  input  logic [15:0] EXT_AD_OUT,
  input  logic        EXT_READ,
  input  logic        EXT_WRITE,
  output logic [7:0]  EXT_AD_IN,
  output logic        EXT_READY
);

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [7:0]  CNT_LOAD = NO_WAIT ? 8'd0 : 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_READY
  } state_t;

  state_t                 state;
  logic                   phase;
  logic                   ae_q;
  logic [31:0]            addr;
  logic [7:0]             wdata;
  logic [7:0]             cnt;
  logic                   op_rd;
  logic [7:0]             mem [DEPTH];

  logic                   sel;
  logic                   ae_fall;
  logic                   strobe;
  logic                   commit;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   idx;

  // Address decode and access qualifiers.
  assign idx     = addr[ADDR_BITS-1:0];
  assign sel     = (addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign ae_fall = ae_q & ~AE;
  assign strobe  = EXT_READ | EXT_WRITE;
  // The first READY cycle (EXT_READY still low) is where the access takes
  // effect; an AE in that cycle aborts it before anything is committed.
  assign commit  = (state == S_READY) && !EXT_READY && !AE;
  assign mem_we  = commit && !op_rd;

  // Byte memory; contents deliberately not reset, writes suppressed under rst.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[idx] <= wdata;
    end
  end

  // Address capture, write-data latch and access FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= 1'b0;
      ae_q      <= 1'b0;
      addr      <= 32'h0;
      wdata     <= 8'h00;
      cnt       <= 8'd0;
      op_rd     <= 1'b0;
      EXT_READY <= 1'b0;
      EXT_AD_IN <= 8'h00;
    end else begin
      ae_q <= AE;

      // Two AE phases: low half first, then high half.
      if (AE) begin
        phase <= ~phase;
        if (!phase) begin
          addr[15:0] <= EXT_AD_OUT;
        end else begin
          addr[31:16] <= EXT_AD_OUT;
        end
      end else begin
        phase <= 1'b0;
      end

      if (ae_fall) begin
        wdata <= EXT_AD_OUT[7:0];
      end

      EXT_READY <= 1'b0;
      EXT_AD_IN <= 8'h00;

      case (state)
        S_IDLE: begin
          if (ae_fall) begin
            state <= S_ARMED;
          end
        end

        S_ARMED: begin
          // A new address cycle restarts the handshake.
          if (AE) begin
            state <= S_IDLE;
          end else if (strobe && sel) begin
            op_rd <= EXT_READ;
            if (NO_WAIT) begin
              state <= S_READY;
            end else begin
              cnt   <= CNT_LOAD;
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // Counting continues even if the strobe drops; the access still completes.
          if (AE) begin
            state <= S_IDLE;
          end else if (cnt == 8'd0) begin
            state <= S_READY;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_READY: begin
          if (AE) begin
            state <= S_IDLE;
          end else begin
            EXT_READY <= 1'b1;
            if (!EXT_READY) begin
              if (op_rd) begin
                EXT_AD_IN <= mem[idx];
              end
            end else begin
              EXT_AD_IN <= EXT_AD_IN;
            end
            // EXT_READY stays high one more cycle after leaving, so it falls
            // on the edge after the strobes are seen low.
            if (!strobe) begin
              state <= S_ARMED;
`ifdef EXT_RESP_AUTOINC_EN
              addr[ADDR_BITS-1:0] <= idx + ADDR_BITS'(1);
`endif
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_responder.sv
// Bench for ext_bus_responder: two instances (3 and 0 wait states) share one
// MCU bus; read expectations are queued when the strobe is driven and
// compared when EXT_READY is seen.
module tb_ext_bus_responder;

  localparam int unsigned W3 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        AE;
  logic [15:0] EXT_AD_OUT;
  logic        EXT_READ;
  logic        EXT_WRITE;
  logic [7:0]  ad3, ad0;
  logic        rdy3, rdy0;

  int          n_vec = 0;
  int          n_err = 0;

  logic [7:0]  m3 [4096];
  logic [7:0]  m0 [4096];
  logic [7:0]  q3 [$];
  logic [7:0]  q0 [$];
  logic [11:0] cur_idx;
  logic [7:0]  cur_wd;

  always #5 clk = ~clk;

  ext_bus_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(W3)) u3 (
    .clk(clk), .rst(rst), .AE(AE), .EXT_AD_OUT(EXT_AD_OUT),
    .EXT_READ(EXT_READ), .EXT_WRITE(EXT_WRITE),
    .EXT_AD_IN(ad3), .EXT_READY(rdy3)
  );

  ext_bus_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .AE(AE), .EXT_AD_OUT(EXT_AD_OUT),
    .EXT_READ(EXT_READ), .EXT_WRITE(EXT_WRITE),
    .EXT_AD_IN(ad0), .EXT_READY(rdy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two address phases then AE release carrying the write byte.
  task automatic ae_phase(input logic [31:0] a, input logic [7:0] wd);
    AE = 1'b1; EXT_AD_OUT = a[15:0];
    tick();
    EXT_AD_OUT = a[31:16];
    tick();
    AE = 1'b0; EXT_AD_OUT = {8'h00, wd};
    tick();
    cur_idx = a[11:0];
    cur_wd  = wd;
  endtask

  // One full selected access at the currently latched address.
  task automatic do_access(input logic rd);
    int k = 0;
    int k0 = 0;
    logic [7:0] e;
    EXT_READ  = rd;
    EXT_WRITE = !rd;
    if (rd) begin
      q3.push_back(m3[cur_idx]);
      q0.push_back(m0[cur_idx]);
    end else begin
      m3[cur_idx] = cur_wd;
      m0[cur_idx] = cur_wd;
    end
    tick();
    check("ready_early3", 32'(rdy3), 0);
    check("ready_early0", 32'(rdy0), 0);
    do begin
      tick();
      k++;
      if (k0 == 0 && rdy0) k0 = k;
      if (!rdy3) check("idle_data3", 32'(ad3), 0);
    end while (!rdy3 && k < 40);
    check("latency3", k, W3 + 1);
    check("latency0", k0, 1);
    if (rd) begin
      e = q3.pop_front();
      check("rdata3", 32'(ad3), 32'(e));
      e = q0.pop_front();
      check("rdata0", 32'(ad0), 32'(e));
    end
    EXT_READ  = 1'b0;
    EXT_WRITE = 1'b0;
    tick();
    check("ready_hold3", 32'(rdy3), 1);
    tick();
    check("ready_fall3", 32'(rdy3), 0);
    check("data_clr3", 32'(ad3), 0);
    check("ready_fall0", 32'(rdy0), 0);
    check("data_clr0", 32'(ad0), 0);
`ifdef EXT_RESP_AUTOINC_EN
    cur_idx = cur_idx + 12'd1;
`endif
  endtask

  initial begin
    int k;
    rst = 1'b1; AE = 1'b0; EXT_AD_OUT = 16'h0000; EXT_READ = 1'b0; EXT_WRITE = 1'b0;
    cur_idx = 12'h000; cur_wd = 8'h00;
    tick();
    tick();
    check("rst_ready3", 32'(rdy3), 0);
    check("rst_data3", 32'(ad3), 0);
    check("rst_ready0", 32'(rdy0), 0);
    check("rst_data0", 32'(ad0), 0);
    rst = 1'b0;
    tick();

    // Write 8'hA5 to 0x0000_1234, then read it back.
    ae_phase(32'h0000_1234, 8'hA5);
    do_access(1'b0);
    ae_phase(32'h0000_1234, 8'h00);
    do_access(1'b1);

    // Unselected address: strobe held, no response.
    ae_phase(32'h0000_2010, 8'h00);
    EXT_READ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("unsel_ready3", 32'(rdy3), 0);
      check("unsel_data3", 32'(ad3), 0);
      check("unsel_ready0", 32'(rdy0), 0);
    end
    EXT_READ = 1'b0;
    tick();

    // Back-to-back writes without AE (wrap under auto-increment), W=0 read of 0x1FFF.
    ae_phase(32'h0000_1000, 8'h22);
    do_access(1'b0);
    ae_phase(32'h0000_1FFF, 8'h11);
    do_access(1'b0);
    do_access(1'b0);
    ae_phase(32'h0000_1000, 8'h00);
    do_access(1'b1);
    ae_phase(32'h0000_1FFF, 8'h00);
    do_access(1'b1);

    // Abort: AE reasserted two cycles into WAIT during a write of 8'h3C.
    ae_phase(32'h0000_1005, 8'h77);
    do_access(1'b0);
    ae_phase(32'h0000_1005, 8'h3C);
    EXT_WRITE = 1'b1;
    tick();
    check("abort_ready_n", 32'(rdy3), 0);
    tick();
    check("abort_ready_n1", 32'(rdy3), 0);
    check("abort_commit0", 32'(rdy0), 1);
    AE = 1'b1; EXT_AD_OUT = 16'h1005; EXT_WRITE = 1'b0;
    tick();
    check("abort_ready_n2", 32'(rdy3), 0);
    check("abort_drop0", 32'(rdy0), 0);
    EXT_AD_OUT = 16'h0000;
    tick();
    AE = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet3", 32'(rdy3), 0);
    end
    m0[12'h005] = 8'h3C;
    cur_idx = 12'h005;
    do_access(1'b1);

    // Reset while READY: outputs clear, memory survives.
    ae_phase(32'h0000_1020, 8'h5A);
    do_access(1'b0);
    ae_phase(32'h0000_1020, 8'h00);
    EXT_READ = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!rdy3 && k < 40);
    check("rst_pre_ready", 32'(rdy3), 1);
    check("rst_pre_data", 32'(ad3), 32'h5A);
    rst = 1'b1;
    tick();
    check("rst_mid_ready3", 32'(rdy3), 0);
    check("rst_mid_data3", 32'(ad3), 0);
    check("rst_mid_ready0", 32'(rdy0), 0);
    check("rst_mid_data0", 32'(ad0), 0);
    rst = 1'b0;
    EXT_READ = 1'b0;
    tick();
    check("rst_after3", 32'(rdy3), 0);
    ae_phase(32'h0000_1020, 8'h00);
    do_access(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
